cpu_bus_target_mux: RTL and testbench



---
 rtl/cpu_bus_target_mux.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_bus_target_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_target_mux.sv
// cpu_bus_target_mux
// Responder-side bus mux: decodes the initiator address onto one of four
// target ports, registers the target response and returns it with a
// one-cycle ready pulse. Unmapped addresses complete immediately with an
// error flag.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   -> an ACCESS-cycle counter forces an error response after
//                TIMEOUT cycles without target ready.
//   undefined -> ACCESS waits for the target indefinitely.
module cpu_bus_target_mux #(
    parameter logic [31:0] T0_BASE = 32'h0000_0000,
    parameter logic [31:0] T0_MASK = 32'hF000_0000,
    parameter logic [31:0] T1_BASE = 32'h1000_0000,
    parameter logic [31:0] T1_MASK = 32'hF000_0000,
    parameter logic [31:0] T2_BASE = 32'h2000_0000,
    parameter logic [31:0] T2_MASK = 32'hF000_0000,
    parameter logic [31:0] T3_BASE = 32'h3000_0000,
    parameter logic [31:0] T3_MASK = 32'hF000_0000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    // initiator side
    input  logic          i_bus_rw,
    input  logic          i_bus_request,
    output logic          o_bus_ready,
    input  logic [31:0]   i_bus_address,
    output logic [31:0]   o_bus_rdata,
    input  logic [31:0]   i_bus_wdata,
    output logic          o_bus_error,
    // target side
    output logic [3:0]    o_t_request,
    output logic          o_t_rw,
    output logic [31:0]   o_t_address,
    output logic [31:0]   o_t_wdata,
    input  logic [3:0]    i_t_ready,
    input  logic [127:0]  i_t_rdata
);

    // One-hot style encoding; every other code is treated as illegal and
    // recovers to IDLE.
    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        ACCESS  = 3'b001,
        RESPOND = 3'b010,
        RELEASE = 3'b100
    } state_t;

    state_t       r_state;
    logic [1:0]   r_sel;
    logic [3:0]   r_t_request;
    logic         r_t_rw;
    logic [31:0]  r_t_address;
    logic [31:0]  r_t_wdata;
    logic         r_bus_ready;
    logic         r_bus_error;
    logic [31:0]  r_bus_rdata;

    logic         w_hit;
    logic [1:0]   w_hit_idx;
    logic         w_sel_ready;
    logic [31:0]  w_sel_rdata;
    logic         w_timeout;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // r_cnt holds the number of ACCESS cycles already completed; w_cnt_next
    // counts the current cycle too, so the forced error lands on the
    // TIMEOUT-th ACCESS edge.
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT));
`else
    assign w_timeout  = 1'b0;
`endif

    // Address decode; checked from highest to lowest index so the lowest
    // matching target is the one left standing on overlap.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        w_hit     = 1'b0;
        w_hit_idx = 2'd0;
        if ((i_bus_address & T3_MASK) == T3_BASE) begin
            w_hit     = 1'b1;
            w_hit_idx = 2'd3;
        end
        if ((i_bus_address & T2_MASK) == T2_BASE) begin
            w_hit     = 1'b1;
            w_hit_idx = 2'd2;
        end
        if ((i_bus_address & T1_MASK) == T1_BASE) begin
            w_hit     = 1'b1;
            w_hit_idx = 2'd1;
        end
        if ((i_bus_address & T0_MASK) == T0_BASE) begin
            w_hit     = 1'b1;
            w_hit_idx = 2'd0;
        end
    end

    // Only the selected target's ready and read data are ever looked at.
    always_comb begin
        w_sel_ready = i_t_ready[r_sel];
        w_sel_rdata = i_t_rdata[{r_sel, 5'd0} +: 32];
    end

    // Transaction FSM with all bus and target outputs registered.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_sel       <= 2'd0;
            r_t_request <= 4'd0;
            r_t_rw      <= 1'b0;
            r_t_address <= 32'd0;
            r_t_wdata   <= 32'd0;
            r_bus_ready <= 1'b0;
            r_bus_error <= 1'b0;
            r_bus_rdata <= 32'd0;
`ifdef BUS_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            case (r_state)
                IDLE: begin
                    if (i_bus_request) begin
                        if (w_hit) begin
                            r_t_rw      <= i_bus_rw;
                            r_t_address <= i_bus_address;
                            r_t_wdata   <= i_bus_wdata;
                            r_sel       <= w_hit_idx;
                            r_t_request <= 4'b0001 << w_hit_idx;
`ifdef BUS_TIMEOUT_EN
                            r_cnt       <= '0;
`endif
                            r_state     <= ACCESS;
                        end else begin
                            // Unmapped: complete at once so the CPU never stalls.
                            r_bus_ready <= 1'b1;
                            r_bus_error <= 1'b1;
                            r_bus_rdata <= 32'd0;
                            r_state     <= RESPOND;
                        end
                    end
                end

                ACCESS: begin
                    if (w_sel_ready) begin
                        // Ready beats a coincident timeout.
                        r_t_request <= 4'd0;
                        r_bus_rdata <= w_sel_rdata;
                        r_bus_ready <= 1'b1;
                        r_bus_error <= 1'b0;
                        r_state     <= RESPOND;
                    end else if (w_timeout) begin
                        r_t_request <= 4'd0;
                        r_bus_rdata <= 32'd0;
                        r_bus_ready <= 1'b1;
                        r_bus_error <= 1'b1;
                        r_state     <= RESPOND;
                    end else begin
`ifdef BUS_TIMEOUT_EN
                        r_cnt       <= w_cnt_next;
`endif
                    end
                end

                RESPOND: begin
                    // Ready/error are a single-cycle pulse; rdata holds.
                    r_bus_ready <= 1'b0;
                    r_bus_error <= 1'b0;
                    r_state     <= RELEASE;
                end

                RELEASE: begin
                    // A request still held high must not re-issue the access.
                    if (!i_bus_request) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_t_request <= 4'd0;
                    r_bus_ready <= 1'b0;
                    r_bus_error <= 1'b0;
                end
            endcase
        end
    end

    assign o_bus_ready = r_bus_ready;
    assign o_bus_error = r_bus_error;
    assign o_bus_rdata = r_bus_rdata;
    assign o_t_request = r_t_request;
    assign o_t_rw      = r_t_rw;
    assign o_t_address = r_t_address;
    assign o_t_wdata   = r_t_wdata;

endmodule

// File: tb/tb_cpu_bus_target_mux.sv
// Self-checking bench for cpu_bus_target_mux. Targets are modelled as
// responders with a chosen number of wait cycles; expectations come from a
// transaction-level model (address region -> target, wait count -> latency).
// Honours BUS_TIMEOUT_EN (bench then uses TIMEOUT=4).
module tb_cpu_bus_target_mux;

`ifdef BUS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam bit TO_EN      = 1'b1;
`else
    localparam int TB_TIMEOUT = 255;
    localparam bit TO_EN      = 1'b0;
`endif

    logic          i_clock;
    logic          i_reset_n;
    logic          i_bus_rw;
    logic          i_bus_request;
    logic          o_bus_ready;
    logic [31:0]   i_bus_address;
    logic [31:0]   o_bus_rdata;
    logic [31:0]   i_bus_wdata;
    logic          o_bus_error;
    logic [3:0]    o_t_request;
    logic          o_t_rw;
    logic [31:0]   o_t_address;
    logic [31:0]   o_t_wdata;
    logic [3:0]    i_t_ready;
    logic [127:0]  i_t_rdata;

    int n_total = 0;
    int n_bad   = 0;

    cpu_bus_target_mux #(.TIMEOUT(TB_TIMEOUT)) dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_bus_rw      (i_bus_rw),
        .i_bus_request (i_bus_request),
        .o_bus_ready   (o_bus_ready),
        .i_bus_address (i_bus_address),
        .o_bus_rdata   (o_bus_rdata),
        .i_bus_wdata   (i_bus_wdata),
        .o_bus_error   (o_bus_error),
        .o_t_request   (o_t_request),
        .o_t_rw        (o_t_rw),
        .o_t_address   (o_t_address),
        .o_t_wdata     (o_t_wdata),
        .i_t_ready     (i_t_ready),
        .i_t_rdata     (i_t_rdata)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Address map model: each 256 MB region 0..3 belongs to that target.
    function automatic int decode(input logic [31:0] addr);
        if (addr[31:28] < 4'd4) return int'(addr[31:28]);
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(o_bus_ready), 32'd0);
        check({tag, "_error"}, 32'(o_bus_error), 32'd0);
        check({tag, "_treq"},  32'(o_t_request), 32'd0);
    endtask

    task automatic do_reset();
        i_reset_n     = 1'b0;
        i_bus_request = 1'b0;
        i_bus_rw      = 1'b0;
        i_bus_address = 32'd0;
        i_bus_wdata   = 32'd0;
        i_t_ready     = 4'd0;
        repeat (2) @(negedge i_clock);
        check_idle_outputs("reset");
        check("reset_rdata", o_bus_rdata, 32'd0);
        check("reset_taddr", o_t_address, 32'd0);
        check("reset_twdata", o_t_wdata, 32'd0);
        check("reset_trw", 32'(o_t_rw), 32'd0);
        i_reset_n = 1'b1;
        @(negedge i_clock);
    endtask

    // One transaction. k = target wait cycles (-1: target never ready),
    // hold = extra cycles the request stays high after completion.
    task automatic run_txn(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] sel_rdata, input int k, input int hold);
        int          tgt;
        int          exp_lat;
        int          lat;
        int          acc;
        int          budget;
        bit          exp_err;
        bit          got;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_req;
        logic [31:0] noise;

        tgt = decode(addr);
        for (int i = 0; i < 4; i++) i_t_rdata[i*32 +: 32] = $urandom;
        if (tgt >= 0) i_t_rdata[tgt*32 +: 32] = sel_rdata;
        exp_req = (tgt >= 0) ? 4'(1 << tgt) : 4'd0;

        if (tgt < 0) begin
            exp_lat = 1; exp_err = 1'b1; exp_rdata = 32'd0;
        end else if (TO_EN && (k < 0 || k + 1 > TB_TIMEOUT)) begin
            exp_lat = TB_TIMEOUT + 1; exp_err = 1'b1; exp_rdata = 32'd0;
        end else if (k < 0) begin
            exp_lat = 0; exp_err = 1'b0; exp_rdata = 32'd0;
        end else begin
            exp_lat = 2 + k; exp_err = 1'b0; exp_rdata = sel_rdata;
        end
        budget = (exp_lat > 0) ? exp_lat + 20 : 1000;

        @(negedge i_clock);
        i_bus_request = 1'b1;
        i_bus_rw      = rw;
        i_bus_address = addr;
        i_bus_wdata   = wdata;
        i_t_ready     = 4'd0;

        lat = 0; acc = 0; got = 1'b0;
        while (!got && lat < budget) begin
            @(negedge i_clock);
            lat++;
            if (o_bus_ready) begin
                got = 1'b1;
            end else begin
                check("t_request", 32'(o_t_request), 32'(exp_req));
                if (tgt >= 0) begin
                    check("t_address", o_t_address, addr);
                    check("t_wdata", o_t_wdata, wdata);
                    check("t_rw", 32'(o_t_rw), 32'(rw));
                end
                noise     = $urandom;
                i_t_ready = noise[3:0];
                if (tgt >= 0) i_t_ready[tgt] = (k >= 0 && acc == k);
                acc++;
            end
        end

        if (exp_lat > 0) begin
            check("ready_seen", 32'(got), 32'd1);
            check("latency", 32'(lat), 32'(exp_lat));
            check("rdata", o_bus_rdata, exp_rdata);
            check("error", 32'(o_bus_error), 32'(exp_err));
            check("t_request_drop", 32'(o_t_request), 32'd0);
            i_t_ready = 4'd0;
            @(negedge i_clock);
            check("ready_pulse", 32'(o_bus_ready), 32'd0);
            check("error_pulse", 32'(o_bus_error), 32'd0);
            for (int h = 0; h < hold; h++) begin
                @(negedge i_clock);
                check("hold_treq", 32'(o_t_request), 32'd0);
                check("hold_ready", 32'(o_bus_ready), 32'd0);
                check("hold_rdata", o_bus_rdata, exp_rdata);
            end
            i_bus_request = 1'b0;
            @(negedge i_clock);
        end else begin
            check("hang_no_ready", 32'(got), 32'd0);
            check("hang_treq", 32'(o_t_request), 32'(exp_req));
            do_reset();
        end
    endtask

    initial begin
        i_t_rdata = '0;
        do_reset();

        // Directed cases from the access patterns of interest.
        run_txn(1'b0, 32'h1000_0010, 32'h0000_0000, 32'hCAFE_0001, 0, 0);
        run_txn(1'b1, 32'h2000_0004, 32'h1234_5678, 32'h5555_AAAA, 3, 0);
        run_txn(1'b0, 32'h9000_0000, 32'h0000_0000, 32'h0,         0, 0);
        run_txn(1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0BAD_F00D, 1, 4);
        run_txn(1'b0, 32'h3FFF_FFFC, 32'h0,         32'h3333_0003, 2, 0);
        run_txn(1'b0, 32'h4000_0000, 32'h0,         32'h0,         0, 1);
        run_txn(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
        run_txn(1'b0, 32'h1000_0000, 32'h0,         32'h1234_0000, TB_TIMEOUT - 1, 0);

        // Target 3 never answers: timeout error, or a permanent stall.
        run_txn(1'b0, 32'h3000_0040, 32'h0, 32'hDEAD_BEEF, -1, 0);
        run_txn(1'b0, 32'h1000_0020, 32'h0, 32'h1111_2222, 0, 0);

        // Reset in the middle of ACCESS: target request drops asynchronously.
        @(negedge i_clock);
        i_bus_request = 1'b1;
        i_bus_rw      = 1'b0;
        i_bus_address = 32'h0000_0080;
        i_t_ready     = 4'd0;
        repeat (2) @(negedge i_clock);
        check("pre_reset_treq", 32'(o_t_request), 32'd1);
        #2 i_reset_n = 1'b0;
        #1 check_idle_outputs("async_reset_access");
        @(negedge i_clock);
        i_bus_request = 1'b0;
        i_reset_n     = 1'b1;
        run_txn(1'b0, 32'h0000_0084, 32'h0, 32'hA5A5_5A5A, 0, 0);

        // Reset during an error pulse clears ready/error asynchronously.
        @(negedge i_clock);
        i_bus_request = 1'b1;
        i_bus_address = 32'hF000_0000;
        @(negedge i_clock);
        check("pre_reset_ready", 32'(o_bus_ready), 32'd1);
        #2 i_reset_n = 1'b0;
        #1 check_idle_outputs("async_reset_respond");
        @(negedge i_clock);
        i_bus_request = 1'b0;
        i_reset_n     = 1'b1;
        run_txn(1'b1, 32'h2000_0000, 32'h0F0F_0F0F, 32'h2222_0002, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] addr;
            int          region;
            region = int'($urandom_range(0, 5));
            addr   = $urandom;
            if (region < 4) addr[31:28] = 4'(region);
            else            addr[31:28] = 4'($urandom_range(4, 15));
            run_txn(1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
